// File: rtl/ascii_hex_accum.sv
// ASCII-hex character stream to binary word accumulator with valid/ready on both sides.
// Optional HEX_UPPER_EN: when defined, 'A'-'F' decode like 'a'-'f'; otherwise they are invalid.
module ascii_hex_accum #(
    parameter int unsigned DIGITS    = 8,
    parameter logic [7:0]  TERM_CHAR = 8'h0D,
    localparam int unsigned W        = 4 * DIGITS,
    localparam int unsigned CW       = $clog2(DIGITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    char_in,
    input  logic          char_valid,
    output logic          char_ready,
    output logic [W-1:0]  word_out,
    output logic          word_valid,
    input  logic          word_ready,
    output logic [CW-1:0] digit_count,
    output logic          err
);

    typedef enum logic {ST_ACCUM, ST_OUT} state_t;
    typedef enum logic [1:0] {CH_DIGIT, CH_TERM, CH_BAD} char_kind_t;

    localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

    state_t        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  word_q, word_d;
    logic          word_valid_q, word_valid_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          ready_q, ready_d;

    char_kind_t    kind;
    logic [3:0]    nibble;
    logic [W-1:0]  acc_shift;
    logic          accept;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        kind   = CH_BAD;
        nibble = 4'h0;
        if (char_in >= 8'h30 && char_in <= 8'h39) begin
            kind   = CH_DIGIT;
            nibble = char_in[3:0];
        end else if (char_in >= 8'h61 && char_in <= 8'h66) begin
            kind   = CH_DIGIT;
            nibble = char_in[3:0] + 4'd9;
        end
`ifdef HEX_UPPER_EN
        else if (char_in >= 8'h41 && char_in <= 8'h46) begin
            kind   = CH_DIGIT;
            nibble = char_in[3:0] + 4'd9;
        end
`endif
        else if (char_in == TERM_CHAR) begin
            kind = CH_TERM;
        end
    end

    // Shift form written so that a single-digit word (W == 4) is still legal.
    assign acc_shift = (acc_q << 4) | W'(nibble);
    assign accept    = char_valid & ready_q;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        word_d       = word_q;
        word_valid_d = word_valid_q;
        cnt_d        = cnt_q;
        err_d        = 1'b0;
        ready_d      = ready_q;
        case (state_q)
            ST_ACCUM: begin
                ready_d = 1'b1;
                if (accept) begin
                    case (kind)
                        CH_DIGIT: begin
                            acc_d = acc_shift;
                            cnt_d = cnt_q + CW'(1);
                            if (cnt_q == LAST_DIGIT) begin
                                word_d       = acc_shift;
                                word_valid_d = 1'b1;
                                ready_d      = 1'b0;
                                state_d      = ST_OUT;
                            end
                        end
                        CH_TERM: begin
                            // A terminator with nothing collected is silently dropped.
                            if (cnt_q != '0) begin
                                word_d       = acc_q;
                                word_valid_d = 1'b1;
                                ready_d      = 1'b0;
                                state_d      = ST_OUT;
                            end
                        end
                        default: begin
                            err_d = 1'b1;
                            acc_d = '0;
                            cnt_d = '0;
                        end
                    endcase
                end
            end
            ST_OUT: begin
                ready_d = 1'b0;
                if (word_ready) begin
                    word_valid_d = 1'b0;
                    acc_d        = '0;
                    cnt_d        = '0;
                    ready_d      = 1'b1;
                    state_d      = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_ACCUM;
            acc_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            ready_q      <= ready_d;
        end
    end

    assign char_ready  = ready_q;
    assign word_out    = word_q;
    assign word_valid  = word_valid_q;
    assign digit_count = cnt_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ascii_hex_accum.sv
// Directed bench for ascii_hex_accum: a DIGITS=4 and a DIGITS=8 instance share clock and reset.
module tb_ascii_hex_accum;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  ch4 = 8'h00;
    logic        cv4 = 1'b0;
    logic        rdy4;
    logic [15:0] word4;
    logic        wv4;
    logic        wr4 = 1'b1;
    logic [2:0]  dc4;
    logic        err4;

    logic [7:0]  ch8 = 8'h00;
    logic        cv8 = 1'b0;
    logic        rdy8;
    logic [31:0] word8;
    logic        wv8;
    logic        wr8 = 1'b1;
    logic [3:0]  dc8;
    logic        err8;

    ascii_hex_accum #(.DIGITS(4), .TERM_CHAR(8'h0D)) dut4 (
        .clk(clk), .rst(rst), .char_in(ch4), .char_valid(cv4), .char_ready(rdy4),
        .word_out(word4), .word_valid(wv4), .word_ready(wr4), .digit_count(dc4), .err(err4)
    );

    ascii_hex_accum #(.DIGITS(8), .TERM_CHAR(8'h0D)) dut8 (
        .clk(clk), .rst(rst), .char_in(ch8), .char_valid(cv8), .char_ready(rdy8),
        .word_out(word8), .word_valid(wv8), .word_ready(wr8), .digit_count(dc8), .err(err8)
    );

    int tests  = 0;
    int failed = 0;

    // Event counters for dut4, sampled mid-cycle.
    int words4 = 0;
    int errs4  = 0;
    always @(negedge clk) begin
        if (!rst && wv4 && wr4) words4 <= words4 + 1;
        if (!rst && err4)       errs4  <= errs4 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic [7:0] c);
        int n;
        n   = 0;
        ch4 = c;
        cv4 = 1'b1;
        while (!rdy4 && n < 50) begin
            tick();
            n++;
        end
        if (!rdy4) begin
            tests++; failed++;
            $display("FAIL send4_timeout char=%h char_ready stayed 0", c);
        end
        tick();
        cv4 = 1'b0;
    endtask

    task automatic send8(input logic [7:0] c);
        int n;
        n   = 0;
        ch8 = c;
        cv8 = 1'b1;
        while (!rdy8 && n < 50) begin
            tick();
            n++;
        end
        if (!rdy8) begin
            tests++; failed++;
            $display("FAIL send8_timeout char=%h char_ready stayed 0", c);
        end
        tick();
        cv8 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        tests++;
        if ({rdy4, wv4, word4, dc4, err4} !== 22'd0) begin
            failed++;
            $display("FAIL reset_dut4 got rdy=%b wv=%b word=%h dc=%0d err=%b want all 0",
                     rdy4, wv4, word4, dc4, err4);
        end
        tests++;
        if ({rdy8, wv8, word8, dc8, err8} !== 39'd0) begin
            failed++;
            $display("FAIL reset_dut8 got rdy=%b wv=%b word=%h dc=%0d err=%b want all 0",
                     rdy8, wv8, word8, dc8, err8);
        end
        tick(); tick();
        #2 rst = 1'b0;
        tick();
        tests++;
        if (rdy4 !== 1'b1 || rdy8 !== 1'b1) begin
            failed++;
            $display("FAIL ready_after_reset got rdy4=%b rdy8=%b want 1 1", rdy4, rdy8);
        end
    endtask

    task automatic test_full_word();
        int w0;
        w0  = words4;
        wr4 = 1'b1;
        send4(8'h31); send4(8'h61);
        tests++;
        if (dc4 !== 3'd2) begin
            failed++;
            $display("FAIL full_midcount got %0d want 2", dc4);
        end
        send4(8'h32); send4(8'h66);
        tests++;
        if (wv4 !== 1'b1 || word4 !== 16'h1A2F || rdy4 !== 1'b0 || dc4 !== 3'd4) begin
            failed++;
            $display("FAIL full_word got wv=%b word=%h rdy=%b dc=%0d want 1 1a2f 0 4",
                     wv4, word4, rdy4, dc4);
        end
        tick();
        tests++;
        if (wv4 !== 1'b0 || dc4 !== 3'd0 || rdy4 !== 1'b1) begin
            failed++;
            $display("FAIL full_after_hs got wv=%b dc=%0d rdy=%b want 0 0 1", wv4, dc4, rdy4);
        end
        tests++;
        if (words4 - w0 !== 1) begin
            failed++;
            $display("FAIL full_word_count got %0d want 1", words4 - w0);
        end
    endtask

    task automatic test_terminator();
        int w0, e0;
        send4(8'h33); send4(8'h63); send4(8'h0D);
        tests++;
        if (wv4 !== 1'b1 || word4 !== 16'h003C) begin
            failed++;
            $display("FAIL term_word got wv=%b word=%h want 1 003c", wv4, word4);
        end
        tick();
        w0 = words4;
        e0 = errs4;
        send4(8'h0D);
        tick(); tick();
        tests++;
        if (words4 != w0 || errs4 != e0 || wv4 !== 1'b0 || dc4 !== 3'd0 || rdy4 !== 1'b1) begin
            failed++;
            $display("FAIL lone_term got words=%0d errs=%0d wv=%b dc=%0d rdy=%b want 0 0 0 0 1",
                     words4 - w0, errs4 - e0, wv4, dc4, rdy4);
        end
    endtask

    task automatic test_invalid();
        int w0;
        w0 = words4;
        send4(8'h31); send4(8'h67);
        tests++;
        if (err4 !== 1'b1 || dc4 !== 3'd0) begin
            failed++;
            $display("FAIL invalid_err got err=%b dc=%0d want 1 0", err4, dc4);
        end
        tick();
        tests++;
        if (err4 !== 1'b0 || words4 != w0) begin
            failed++;
            $display("FAIL invalid_pulse got err=%b words=%0d want 0 0", err4, words4 - w0);
        end
        send4(8'h62); send4(8'h65); send4(8'h65); send4(8'h66);
        tests++;
        if (wv4 !== 1'b1 || word4 !== 16'hBEEF) begin
            failed++;
            $display("FAIL invalid_recover got wv=%b word=%h want 1 beef", wv4, word4);
        end
        tick();
    endtask

    task automatic test_upper();
        int w0, e0;
        w0 = words4;
        e0 = errs4;
        send4(8'h41);
`ifdef HEX_UPPER_EN
        tests++;
        if (err4 !== 1'b0 || dc4 !== 3'd1) begin
            failed++;
            $display("FAIL upper_first got err=%b dc=%0d want 0 1", err4, dc4);
        end
        send4(8'h42); send4(8'h43); send4(8'h44);
        tests++;
        if (wv4 !== 1'b1 || word4 !== 16'hABCD) begin
            failed++;
            $display("FAIL upper_word got wv=%b word=%h want 1 abcd", wv4, word4);
        end
        tick(); tick();
`else
        tests++;
        if (err4 !== 1'b1 || dc4 !== 3'd0) begin
            failed++;
            $display("FAIL upper_first got err=%b dc=%0d want 1 0", err4, dc4);
        end
        send4(8'h42); send4(8'h43); send4(8'h44);
        tick(); tick();
        tests++;
        if (errs4 - e0 != 4 || words4 != w0) begin
            failed++;
            $display("FAIL upper_invalid got errs=%0d words=%0d want 4 0", errs4 - e0, words4 - w0);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [7:0] msg [8];
        msg = '{8'h64, 8'h65, 8'h61, 8'h64, 8'h62, 8'h65, 8'h65, 8'h66};
        wr8 = 1'b0;
        for (int i = 0; i < 8; i++) send8(msg[i]);
        ch8 = 8'h31;
        cv8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (wv8 !== 1'b1 || word8 !== 32'hDEADBEEF || rdy8 !== 1'b0 || dc8 !== 4'd8) begin
                failed++;
                $display("FAIL hold_cycle%0d got wv=%b word=%h rdy=%b dc=%0d want 1 deadbeef 0 8",
                         i, wv8, word8, rdy8, dc8);
            end
            tick();
        end
        wr8 = 1'b1;
        tick();
        wr8 = 1'b0;
        tests++;
        if (wv8 !== 1'b0 || rdy8 !== 1'b1 || dc8 !== 4'd0) begin
            failed++;
            $display("FAIL hold_release got wv=%b rdy=%b dc=%0d want 0 1 0", wv8, rdy8, dc8);
        end
        tick();
        cv8 = 1'b0;
        tests++;
        if (dc8 !== 4'd1) begin
            failed++;
            $display("FAIL hold_next_accept got dc=%0d want 1", dc8);
        end
    endtask

    task automatic test_async_reset();
        send4(8'h31); send4(8'h32);
        #3 rst = 1'b1;
        #1;
        tests++;
        if ({rdy4, wv4, word4, dc4, err4} !== 22'd0 || dc8 !== 4'd0) begin
            failed++;
            $display("FAIL async_reset got rdy=%b wv=%b word=%h dc=%0d err=%b dc8=%0d want all 0",
                     rdy4, wv4, word4, dc4, err4, dc8);
        end
        tick();
        #2 rst = 1'b0;
        tick();
        wr4 = 1'b1;
        send4(8'h30); send4(8'h30); send4(8'h30); send4(8'h37);
        tests++;
        if (wv4 !== 1'b1 || word4 !== 16'h0007) begin
            failed++;
            $display("FAIL after_reset_word got wv=%b word=%h want 1 0007", wv4, word4);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_terminator();
        test_invalid();
        test_upper();
        test_backpressure();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
